// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte/half/word accesses over a handshaked word-wide port.
// Optional watchdog on the ACCESS wait is enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_we;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [1:0]          r_lane;
  logic                r_mem_we;
  logic [3:0]          r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [31:0]         r_rsp_data;
  logic [4:0]          r_rsp_rd;
  logic                r_rsp_err;

  logic                w_req_err;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_data;
  logic                w_accept;
  logic                w_ack;
  logic                w_timeout;

`ifdef MAU_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TO_CYCLES - 1);
  logic [7:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= 8'd0;
    end else if (r_state != ACCESS) begin
      r_to_cnt <= 8'd0;
    end else if (!mem_ack) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  // Last ACCESS cycle without ack; a coincident ack wins.
  assign w_timeout = (r_state == ACCESS) && !mem_ack && (r_to_cnt == TO_LIMIT);
`else
  // Watchdog compiled out: ACCESS waits for mem_ack indefinitely.
  assign w_timeout = (TO_CYCLES < 0);
`endif

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_ack    = (r_state == ACCESS) && mem_ack;

  always_comb begin
    w_req_err = 1'b0;
    w_be      = 4'b1111;
    w_wdata   = req_wdata;
    case (req_size)
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_req_err = req_addr[0];
        w_be      = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{req_wdata[15:0]}};
      end
      2'b10: w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_data = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_next = w_req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack || w_timeout) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_lane      <= 2'b00;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_rsp_data  <= 32'd0;
      r_rsp_rd    <= 5'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_uns      <= req_unsigned;
      r_lane     <= req_addr[1:0];
      r_rsp_rd   <= req_rd;
      r_rsp_data <= 32'd0;
      r_rsp_err  <= w_req_err;
      if (!w_req_err) begin
        r_mem_we    <= req_we;
        r_mem_be    <= w_be;
        r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        r_mem_wdata <= w_wdata;
      end
    end else if (w_ack) begin
      r_rsp_data <= r_we ? 32'd0 : w_load_data;
      r_rsp_err  <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_data <= 32'd0;
      r_rsp_err  <= 1'b1;
    end
  end

  // mem_en follows the state so an asynchronous reset drops it immediately.
  assign mem_en    = (r_state == ACCESS);
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_rd    = r_rsp_rd;
  assign rsp_err   = r_rsp_err;
  assign req_ready = (r_state == IDLE);
  assign stall     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit, plus hand-written reset and wait sequences.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        stall;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(32), .TO_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_err(rsp_err), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, need 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive_req(v.we, v.size, v.uns, v.addr, v.wdata, v.rd);
    if (v.err) begin
      chk("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("err_rsp_err", {31'd0, rsp_err}, 32'd1);
      chk("err_mem_en", {31'd0, mem_en}, 32'd0);
      chk("err_rsp_data", rsp_data, 32'd0);
      chk("err_rsp_rd", {27'd0, rsp_rd}, {27'd0, v.rd});
    end else begin
      chk("mem_en", {31'd0, mem_en}, 32'd1);
      chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
      chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
      chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
      if (v.we) chk("mem_wdata", mem_wdata, v.mwdata);
      chk("stall", {31'd0, stall}, 32'd1);
      for (int c = 0; c < v.dly; c++) begin
        @(posedge clk);
        @(negedge clk);
        chk("wait_mem_en", {31'd0, mem_en}, 32'd1);
        chk("wait_mem_be", {28'd0, mem_be}, {28'd0, v.be});
        chk("wait_mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        chk("wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("wait_stall", {31'd0, stall}, 32'd1);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      @(posedge clk);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A5A5A;
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_data", rsp_data, v.data);
      chk("rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, v.rd});
      chk("rsp_mem_en", {31'd0, mem_en}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_stall", {31'd0, stall}, 32'd0);
    $display("vec %0d: we=%0d size=%0d addr=0x%08h -> err=%0d data=0x%08h",
             i, v.we, v.size, v.addr, v.err, v.data);
  endtask

  initial begin
    //          we    sz     u     addr          wdata          rd     rdata          d  err   be       mwdata         data
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h00000103, 32'h0,         5'd1,  32'h80123456, 0, 1'b0, 4'b1000, 32'h0,         32'hFFFFFF80};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h00000102, 32'h0,         5'd2,  32'hBEEF1234, 0, 1'b0, 4'b1100, 32'h0,         32'h0000BEEF};
    vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h00000201, 32'h123456A5,  5'd3,  32'hDEADBEEF, 0, 1'b0, 4'b0010, 32'hA5A5A5A5,  32'h0};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h00000206, 32'h0,         5'd4,  32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 2'b11, 1'b0, 32'h00000206, 32'h0,         5'd5,  32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h00000100, 32'h0,         5'd6,  32'h1234F00D, 1, 1'b0, 4'b0011, 32'h0,         32'hFFFFF00D};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h00000101, 32'h0,         5'd7,  32'h11229A44, 0, 1'b0, 4'b0010, 32'h0,         32'h0000009A};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h00000202, 32'hAAAA5678,  5'd8,  32'h0,        0, 1'b0, 4'b1100, 32'h56785678,  32'h0};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h00000204, 32'hCAFEBABE,  5'd9,  32'hFFFFFFFF, 2, 1'b0, 4'b1111, 32'hCAFEBABE,  32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h00000101, 32'h0,         5'd10, 32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0,         5'd11, 32'h89ABCDEF, 3, 1'b0, 4'b1111, 32'h0,         32'h89ABCDEF};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h00000102, 32'h0,         5'd12, 32'h00450000, 0, 1'b0, 4'b0100, 32'h0,         32'h00000045};
    vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h00000100, 32'h0,         5'd31, 32'hFFFFFF80, 0, 1'b0, 4'b0001, 32'h0,         32'h00000080};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;

    // Stray ack while idle must not start anything.
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ack_stall", {31'd0, stall}, 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset asserted in the middle of an outstanding access.
    drive_req(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 5'd13);
    chk("rstmid_mem_en_before", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rstmid_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rstmid_mem_addr", mem_addr, 32'd0);
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    mem_ack = 1'b0;
    $display("reset mid-access: outputs cleared, no response");

`ifdef MAU_TIMEOUT_EN
    // No ack: four ACCESS cycles, then an error response.
    drive_req(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 5'd14);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("to_mem_en", {31'd0, mem_en}, 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    chk("to_mem_en_low", {31'd0, mem_en}, 32'd0);
    @(posedge clk);
    $display("timeout: no ack -> rsp_err after 4 cycles");
    // Ack on the fourth ACCESS cycle wins over the watchdog.
    drive_req(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 5'd15);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("to4_mem_en", {31'd0, mem_en}, 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("to4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to4_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("to4_rsp_data", rsp_data, 32'h0BADF00D);
    @(posedge clk);
    $display("timeout: ack on limit cycle -> normal completion");
`else
    // Without the watchdog a long wait still completes normally.
    drive_req(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 5'd14);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("long_mem_en", {31'd0, mem_en}, 32'd1);
    chk("long_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("long_rsp_valid_ack", {31'd0, rsp_valid}, 32'd1);
    chk("long_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("long_rsp_data", rsp_data, 32'h0BADF00D);
    @(posedge clk);
    $display("long wait: completed after 20 idle cycles");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
